// File: rtl/max_pool2d_stream_pkg.sv
// Shared float32 helpers for the pooling/activation stages: sign-bit constants
// and a sign-magnitude max with a deterministic tie rule.
package max_pool2d_stream_pkg;

  localparam int          FP32_SIGN_BIT = 31;
  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;

  // Raw-bit compare (NaNs just sort by their encoding). On a tie, including
  // +0 against -0, the first operand wins so results stay order-stable.
  function automatic logic [31:0] fp32_fmax(input logic [31:0] a, input logic [31:0] b);
    logic b_wins;
    b_wins = 1'b0;
    if (a[FP32_SIGN_BIT-1:0] == '0 && b[FP32_SIGN_BIT-1:0] == '0)
      b_wins = 1'b0;
    else if (a[FP32_SIGN_BIT] != b[FP32_SIGN_BIT])
      b_wins = a[FP32_SIGN_BIT];
    else if (!a[FP32_SIGN_BIT])
      b_wins = (b[FP32_SIGN_BIT-1:0] > a[FP32_SIGN_BIT-1:0]);
    else
      b_wins = (b[FP32_SIGN_BIT-1:0] < a[FP32_SIGN_BIT-1:0]);
    return b_wins ? b : a;
  endfunction

endpackage

// File: rtl/max_pool2d_stream_max2.sv
// Combinational two-input float32 max; operand a wins ties.
module fp32_max2
  import max_pool2d_stream_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  assign y = fp32_fmax(a, b);

endmodule

// File: rtl/max_pool2d_stream.sv
// Streaming 2x2 stride-2 float32 max pool over a WIDTH x HEIGHT raster stream.
// Define MAX_POOL_RELU_FUSE_EN to clamp negative pooled results to +0.
module max_pool2d_stream
  import max_pool2d_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 5,
  parameter int HEIGHT     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int HALF_W = WIDTH / 2;
  localparam int COL_W  = $clog2(WIDTH);
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int BUF_AW = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam bit ODD_W  = (WIDTH % 2) == 1;
  localparam bit ODD_H  = (HEIGHT % 2) == 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] line_buf [HALF_W];

  logic                  pair_col;
  logic                  pair_row;
  logic                  col_odd;
  logic                  row_odd;
  logic [BUF_AW-1:0]     buf_idx;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] pool_max;
  logic [DATA_WIDTH-1:0] pool_res;

  // A trailing odd column/row has no partner and never enters a window.
  assign pair_col = !(ODD_W && col == COL_LAST);
  assign pair_row = !(ODD_H && row == ROW_LAST);
  assign col_odd  = col[0];
  assign row_odd  = row[0];
  assign buf_idx  = BUF_AW'(col >> 1);

  fp32_max2 u_pair_max (
    .a (hold),
    .b (data_in),
    .y (pair_max)
  );

  fp32_max2 u_pool_max (
    .a (line_buf[buf_idx]),
    .b (pair_max),
    .y (pool_max)
  );

`ifdef MAX_POOL_RELU_FUSE_EN
  assign pool_res = pool_max[FP32_SIGN_BIT] ? FP32_POS_ZERO : pool_max;
`else
  assign pool_res = pool_max;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (!col_odd && pair_col)
          hold <= data_in;
        if (col_odd && pair_row && row_odd) begin
          data_out  <= pool_res;
          valid_out <= 1'b1;
        end
        if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Upper-row pair maxima; contents survive reset and are rewritten by row 0.
  always_ff @(posedge clk) begin
    if (valid_in && !rst && col_odd && pair_row && !row_odd)
      line_buf[buf_idx] <= pair_max;
  end

endmodule
